// File: rtl/div_issue_queue.sv
// Operand FIFO feeding a multi-cycle divider, with a divide-by-zero bypass,
// a stale-done-safe completion wait and a timeout-protected result register.
module div_issue_queue #(
   parameter int W       = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_dividend,
   input  logic [W-1:0] in_divisor,
   output logic         div_start,
   output logic [W-1:0] div_dividend,
   output logic [W-1:0] div_divisor,
   input  logic [W-1:0] div_quotient,
   input  logic [W-1:0] div_remainder,
   input  logic         div_done,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_quotient,
   output logic [W-1:0] out_remainder,
   output logic         out_dbz,
   output logic         out_tmo,
   output logic         busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state, state_n;
   logic [W-1:0]  fifo_dd [DEPTH];
   logic [W-1:0]  fifo_dv [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic [CW-1:0] wcnt;
   logic          push, pop, out_free, full, head_zero, cap, tmo;

   assign full      = (count == (AW+1)'(DEPTH));
   assign in_ready  = !full;
   assign push      = in_valid && in_ready;
   assign out_free  = !out_valid || out_ready;
   assign pop       = (state == IDLE) && (count != '0) && out_free;
   assign head_zero = (fifo_dv[rptr] == '0);
   assign div_start = (state == ISSUE);
   assign busy      = (state != IDLE) || (count != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_dd[wptr] <= in_dividend;
         fifo_dv[wptr] <= in_divisor;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Counter value 0 is the first WAIT cycle; a done seen there is left over
   // from a previous operation and is ignored.
   always_comb begin
      state_n = state;
      cap     = 1'b0;
      tmo     = 1'b0;
      case (state)
         IDLE:  if (pop && !head_zero) state_n = ISSUE;
         ISSUE: state_n = WAIT;
         WAIT: begin
            if (wcnt != '0 && div_done) begin
               cap     = 1'b1;
               state_n = IDLE;
            end else if (wcnt == CW'(TIMEOUT - 1)) begin
               tmo     = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              wcnt <= '0;
      else if (state != WAIT)  wcnt <= '0;
      else                     wcnt <= wcnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_dividend <= '0;
         div_divisor  <= '0;
      end else if (pop) begin
         div_dividend <= fifo_dd[rptr];
         div_divisor  <= fifo_dv[rptr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_quotient  <= '0;
         out_remainder <= '0;
         out_dbz       <= 1'b0;
         out_tmo       <= 1'b0;
      end else if (pop && head_zero) begin
         out_valid     <= 1'b1;
         out_quotient  <= '1;
         out_remainder <= fifo_dd[rptr];
         out_dbz       <= 1'b1;
         out_tmo       <= 1'b0;
      end else if (cap) begin
         out_valid     <= 1'b1;
         out_quotient  <= div_quotient;
         out_remainder <= div_remainder;
         out_dbz       <= 1'b0;
         out_tmo       <= 1'b0;
      end else if (tmo) begin
         out_valid     <= 1'b1;
         out_quotient  <= '0;
         out_remainder <= '0;
         out_dbz       <= 1'b0;
         out_tmo       <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue with a small behavioural divider model.
module tb_div_issue_queue;

   logic       clk, rst_n;
   logic       in_valid, in_ready;
   logic [3:0] in_dividend, in_divisor;
   logic       div_start;
   logic [3:0] div_dividend, div_divisor, div_quotient, div_remainder;
   logic       div_done;
   logic       out_valid, out_ready;
   logic [3:0] out_quotient, out_remainder;
   logic       out_dbz, out_tmo, busy;

   int tests = 0;
   int fails = 0;
   int mode  = 0;   // 0: done 6 cycles after start, 1: never done, 2: done held high
   logic force_done = 1'b0;
   int dcnt = 0;
   int starts = 0;

   div_issue_queue #(.W(4), .DEPTH(4), .TIMEOUT(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_dividend(in_dividend), .in_divisor(in_divisor),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_quotient(out_quotient), .out_remainder(out_remainder),
      .out_dbz(out_dbz), .out_tmo(out_tmo), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (div_start)     dcnt <= 6;
      else if (dcnt > 0) dcnt <= dcnt - 1;
      if (div_start)     starts <= starts + 1;
   end

   assign div_done      = (mode == 0 && dcnt == 1) || (mode == 2) || force_done;
   assign div_quotient  = (div_divisor != 0) ? div_dividend / div_divisor : 4'd0;
   assign div_remainder = (div_divisor != 0) ? div_dividend % div_divisor : 4'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] a, input logic [3:0] b);
      int n = 0;
      in_dividend = a;
      in_divisor  = b;
      in_valid    = 1'b1;
      while (!in_ready && n < 200) begin step(); n++; end
      chk("push_accept", n < 200, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic get(input string tag, input logic [3:0] q, input logic [3:0] r,
                      input logic dbz, input logic tmo);
      int n = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 200) begin step(); n++; end
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_q"}, out_quotient, q);
      chk({tag, "_r"}, out_remainder, r);
      chk({tag, "_dbz"}, out_dbz, dbz);
      chk({tag, "_tmo"}, out_tmo, tmo);
      step();
      out_ready = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (!div_start && n < 50) begin step(); n++; end
      chk({tag, "_start"}, div_start, 1);
   endtask

   task automatic cycles_to_valid(output int n);
      n = 0;
      do begin step(); n++; end while (!out_valid && n < 100);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s0, n;
      logic seen;
      rst_n = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_out_q", out_quotient, 0);
      chk("rst_div_dd", div_dividend, 0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // single operation 13/3
      s0 = starts;
      push(4'd13, 4'd3);
      get("single", 4'd4, 4'd1, 1'b0, 1'b0);
      chk("single_starts", starts - s0, 1);
      chk("single_busy", busy, 0);

      // divide by zero bypass
      s0 = starts;
      push(4'd7, 4'd0);
      chk("dbz_early", out_valid, 0);
      step();
      chk("dbz_lat", out_valid, 1);
      get("dbz", 4'd15, 4'd7, 1'b1, 1'b0);
      chk("dbz_starts", starts - s0, 0);

      // back-pressure fills the FIFO
      out_ready = 1'b0;
      push(4'd9, 4'd2);
      push(4'd8, 4'd4);
      push(4'd15, 4'd1);
      push(4'd6, 4'd5);
      push(4'd3, 4'd3);
      chk("full_in_ready", in_ready, 0);
      repeat (12) step();
      chk("full_hold_q", out_quotient, 4);
      chk("full_hold_valid", out_valid, 1);
      get("full0", 4'd4, 4'd1, 1'b0, 1'b0);
      get("full1", 4'd2, 4'd0, 1'b0, 1'b0);
      get("full2", 4'd15, 4'd0, 1'b0, 1'b0);
      get("full3", 4'd1, 4'd1, 1'b0, 1'b0);
      get("full4", 4'd1, 4'd0, 1'b0, 1'b0);
      chk("full_drained_busy", busy, 0);

      // timeout: 32 WAIT cycles after the ISSUE cycle
      mode = 1;
      push(4'd10, 4'd3);
      wait_start("tmo");
      cycles_to_valid(n);
      chk("tmo_lat", n, 33);
      get("tmo", 4'd0, 4'd0, 1'b0, 1'b1);
      chk("tmo_busy", busy, 0);
      mode = 0;

      // stale done: capture on the second WAIT cycle
      mode = 2;
      push(4'd11, 4'd2);
      wait_start("stale");
      cycles_to_valid(n);
      chk("stale_lat", n, 3);
      get("stale", 4'd5, 4'd1, 1'b0, 1'b0);
      mode = 0;

      // reset during WAIT, then a late done
      push(4'd6, 4'd2);
      wait_start("rst");
      step();
      step();
      chk("rst_mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_busy0", busy, 0);
      chk("rst_mid_div_start", div_start, 0);
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      force_done = 1'b1;
      step();
      if (out_valid) seen = 1'b1;
      force_done = 1'b0;
      repeat (12) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      chk("rst_late_done_valid", seen, 0);
      chk("rst_late_busy", busy, 0);
      chk("rst_late_in_ready", in_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
